// File: rtl/msk_g16mul_issue_stage_if.sv
// Issue-stage bundle: operand/randomness handshakes, multiplier drive/return and product output.
interface msk_g16mul_issue_stage_if #(
    parameter int d    = 2,
    parameter int RW   = 4*d*(d-1),
    parameter int CNTW = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [4*d-1:0]    in_a;
    logic [4*d-1:0]    in_b;
    logic              rnd_valid;
    logic              rnd_ready;
    logic [RW-1:0]     rnd_in;
    logic [4*d-1:0]    mul_ina;
    logic [4*d-1:0]    mul_ina_prev;
    logic [4*d-1:0]    mul_inb;
    logic [RW-1:0]     mul_rnd;
    logic [4*d-1:0]    mul_out;
    logic              out_valid;
    logic              out_ready;
    logic [4*d-1:0]    out_data;
    logic              busy;
    logic [CNTW-1:0]   op_count;

    modport master (
        output in_valid, in_a, in_b, rnd_valid, rnd_in, mul_out, out_ready,
        input  in_ready, rnd_ready, mul_ina, mul_ina_prev, mul_inb, mul_rnd,
               out_valid, out_data, busy, op_count
    );

    modport slave (
        input  in_valid, in_a, in_b, rnd_valid, rnd_in, mul_out, out_ready,
        output in_ready, rnd_ready, mul_ina, mul_ina_prev, mul_inb, mul_rnd,
               out_valid, out_data, busy, op_count
    );
endinterface

// File: rtl/msk_g16mul_issue_stage.sv
// Feeds a masked G(16) multiplier (fixed 1-cycle latency) and collects products into a 2-entry FIFO;
// issue stalls when FIFO occupancy plus the in-flight op would exceed two after this cycle's pop.
module msk_g16mul_issue_stage #(
    parameter int d    = 2,
    parameter int RW   = 4*d*(d-1),
    parameter int CNTW = 16
) (
    input  logic clk,
    input  logic rst,
    msk_g16mul_issue_stage_if.slave io
);
    localparam int W = 4*d;

    logic [1:0]      fifo_cnt_q, fifo_cnt_d;
    logic            inflight_q;
    logic            rd_ptr_q, wr_ptr_q;
    logic [W-1:0]    mem_q [2];
    logic [W-1:0]    ina_prev_q;
    logic [CNTW-1:0] op_count_q;

    logic            pop, push, space, issue;
    logic [2:0]      occ;
    logic [W-1:0]    mul_ina_d;

    always_comb begin
        pop        = (fifo_cnt_q != 2'd0) && io.out_ready;
        push       = inflight_q;
        occ        = 3'(fifo_cnt_q) + 3'(inflight_q) - 3'(pop);
        // Readies are held low while reset is asserted.
        space      = (occ < 3'd2) && !rst;
        issue      = io.in_valid && io.rnd_valid && space;
        fifo_cnt_d = fifo_cnt_q + 2'(push) - 2'(pop);
        mul_ina_d  = issue ? io.in_a : '0;
    end

    assign io.in_ready     = io.rnd_valid && space;
    assign io.rnd_ready    = io.in_valid && space;
    assign io.mul_ina      = mul_ina_d;
    assign io.mul_inb      = issue ? io.in_b : '0;
    assign io.mul_rnd      = issue ? io.rnd_in : '0;
    assign io.mul_ina_prev = ina_prev_q;
    assign io.out_valid    = fifo_cnt_q != 2'd0;
    assign io.out_data     = mem_q[rd_ptr_q];
    assign io.busy         = inflight_q || (fifo_cnt_q != 2'd0);
    assign io.op_count     = op_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_cnt_q <= 2'd0;
            inflight_q <= 1'b0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            ina_prev_q <= '0;
            op_count_q <= '0;
        end else begin
            fifo_cnt_q <= fifo_cnt_d;
            inflight_q <= issue;
            ina_prev_q <= mul_ina_d;
            // The multiplier output is valid exactly one cycle after issue.
            if (push) begin
                mem_q[wr_ptr_q] <= io.mul_out;
                wr_ptr_q        <= ~wr_ptr_q;
                op_count_q      <= op_count_q + CNTW'(1);
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end
endmodule

// File: tb/tb_msk_g16mul_issue_stage.sv
// Randomized bench for the G(16) issue stage with a behavioural multiplier and queue-based reference.
module tb_msk_g16mul_issue_stage;
    localparam int D    = 2;
    localparam int W    = 4*D;
    localparam int RW   = 4*D*(D-1);
    localparam int CNTW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    msk_g16mul_issue_stage_if #(.d(D), .RW(RW), .CNTW(CNTW)) bif ();
    msk_g16mul_issue_stage #(.d(D), .RW(RW), .CNTW(CNTW)) dut (.clk(clk), .rst(rst), .io(bif));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // GF(16) multiply modulo x^4+x+1.
    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r, aa;
        r  = 4'h0;
        aa = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) r = r ^ aa;
            aa = {aa[2:0], 1'b0} ^ (aa[3] ? 4'h3 : 4'h0);
        end
        return r;
    endfunction

    function automatic logic [3:0] unmask(input logic [W-1:0] x);
        logic [3:0] v;
        for (int k = 0; k < 4; k++) v[k] = ^x[k*D +: D];
        return v;
    endfunction

    function automatic logic [W-1:0] share(input logic [3:0] v);
        logic [W-1:0] r;
        logic [D-1:0] s;
        for (int k = 0; k < 4; k++) begin
            s = D'($urandom);
            s[D-1] = v[k] ^ (^s[D-2:0]);
            r[k*D +: D] = s;
        end
        return r;
    endfunction

    // Behavioural multiplier: one-cycle latency, fresh output masks.
    always @(posedge clk) bif.mul_out <= share(gf_mul(unmask(bif.mul_ina), unmask(bif.mul_inb)));

    // Reference model: queue of unmasked products plus one in-flight slot.
    logic [3:0]      mq[$];
    bit              m_infl = 1'b0;
    logic [3:0]      m_infl_val = 4'h0;
    logic [W-1:0]    m_prev = '0;
    logic [CNTW-1:0] m_cnt = '0;
    bit              s_pop = 1'b0, s_issue = 1'b0, e_space = 1'b0;
    logic [3:0]      s_prod = 4'h0;
    logic [W-1:0]    s_ina = '0;
    int              e_occ;

    always @(negedge clk) begin
        s_pop   = (mq.size() != 0) && bif.out_ready;
        e_occ   = mq.size() + int'(m_infl) - int'(s_pop);
        e_space = (e_occ < 2) && !rst;
        s_issue = bif.in_valid && bif.rnd_valid && e_space;
        s_prod  = gf_mul(unmask(bif.in_a), unmask(bif.in_b));
        s_ina   = s_issue ? bif.in_a : '0;
        chk("in_ready",  bif.in_ready,  bif.rnd_valid && e_space);
        chk("rnd_ready", bif.rnd_ready, bif.in_valid && e_space);
        chk("mul_ina",   bif.mul_ina,   s_ina);
        chk("mul_inb",   bif.mul_inb,   s_issue ? bif.in_b : '0);
        chk("mul_rnd",   bif.mul_rnd,   s_issue ? bif.rnd_in : '0);
        chk("mul_ina_prev", bif.mul_ina_prev, m_prev);
        chk("out_valid", bif.out_valid, mq.size() != 0);
        if (mq.size() != 0) chk("out_data", unmask(bif.out_data), mq[0]);
        chk("busy",      bif.busy,      m_infl || (mq.size() != 0));
        chk("op_count",  bif.op_count,  m_cnt);
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_infl = 1'b0;
            m_prev = '0;
            m_cnt  = '0;
        end else begin
            if (s_pop) void'(mq.pop_front());
            if (m_infl) begin
                mq.push_back(m_infl_val);
                m_cnt = m_cnt + 1'b1;
            end
            m_infl     = s_issue;
            m_infl_val = s_prod;
            m_prev     = s_ina;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit iv, input bit rv, input bit ordy);
        bif.in_valid  = iv;
        bif.rnd_valid = rv;
        bif.out_ready = ordy;
        bif.in_a      = share(4'($urandom));
        bif.in_b      = share(4'($urandom));
        bif.rnd_in    = RW'($urandom);
    endtask

    int n_issue;
    logic [W-1:0] hold;

    initial begin
        bif.in_valid = 1'b0; bif.rnd_valid = 1'b0; bif.out_ready = 1'b0;
        bif.in_a = '0; bif.in_b = '0; bif.rnd_in = '0;
        repeat (2) @(posedge clk);
        #1;
        drive(1, 1, 1);
        #1;
        chk("reset_in_ready", bif.in_ready, 1'b0);
        chk("reset_mul_ina", bif.mul_ina, '0);
        chk("reset_out_valid", bif.out_valid, 1'b0);
        chk("reset_out_data", bif.out_data, '0);
        chk("reset_op_count", bif.op_count, '0);
        step();
        drive(0, 0, 1);
        rst = 1'b0;
        step();

        // Single op 0x3 * 0x5
        drive(1, 1, 1);
        bif.in_a = share(4'h3);
        bif.in_b = share(4'h5);
        #1;
        chk("t1_in_ready", bif.in_ready, 1'b1);
        step();
        drive(0, 0, 1);
        #1;
        chk("t1_busy", bif.busy, 1'b1);
        chk("t1_pre_valid", bif.out_valid, 1'b0);
        step();
        chk("t1_out_valid", bif.out_valid, 1'b1);
        chk("t1_product", unmask(bif.out_data), 4'hF);
        chk("t1_op_count", bif.op_count, 32'd1);
        step();

        // Back-to-back stream
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 1);
            #1;
            chk("t2_in_ready", bif.in_ready, 1'b1);
            step();
        end
        drive(0, 0, 1);
        repeat (3) step();
        chk("t2_op_count", bif.op_count, 32'd9);

        // Stalled output: exactly two issues
        n_issue = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0);
            #1;
            if (bif.in_ready) n_issue++;
            step();
        end
        chk("t3_issues", n_issue, 32'd2);
        chk("t3_in_ready", bif.in_ready, 1'b0);
        chk("t3_rnd_ready", bif.rnd_ready, 1'b0);
        hold = bif.out_data;
        repeat (2) step();
        chk("t3_stable", bif.out_data, hold);
        drive(0, 0, 1);
        repeat (4) step();
        chk("t3_drained", bif.out_valid, 1'b0);

        // Operand waiting on randomness
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 1);
            #1;
            chk("t4_in_ready", bif.in_ready, 1'b0);
            chk("t4_mul_rnd", bif.mul_rnd, '0);
            step();
        end
        bif.rnd_valid = 1'b1;
        #1;
        chk("t4_issue", bif.in_ready, 1'b1);
        chk("t4_mul_ina", bif.mul_ina, bif.in_a);
        step();
        drive(0, 0, 1);
        repeat (3) step();

        // Reset right after an issue
        drive(1, 1, 1);
        step();
        drive(0, 0, 1);
        rst = 1'b1;
        #1;
        chk("t5_out_valid", bif.out_valid, 1'b0);
        chk("t5_op_count", bif.op_count, '0);
        chk("t5_busy", bif.busy, 1'b0);
        repeat (2) step();
        rst = 1'b0;
        step();
        chk("t5_no_push", bif.op_count, '0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom), 1'($urandom), 1'($urandom));
            step();
        end
        drive(0, 0, 1);
        repeat (4) step();

        // Counter wrap
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 65535; i++) begin
            drive(1, 1, 1);
            step();
        end
        drive(0, 0, 1);
        repeat (3) step();
        chk("t6_max", bif.op_count, 32'h0000FFFF);
        drive(1, 1, 1);
        step();
        drive(0, 0, 1);
        step();
        chk("t6_wrap", bif.op_count, '0);
        chk("t6_valid", bif.out_valid, 1'b1);
        repeat (2) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
